// File: rtl/ib_pkg.sv
// Shared sizing and state encoding for the fetch/decode instruction buffer controller.
package ib_pkg;
  localparam int IB_DEPTH        = 32;
  localparam int IB_PTR_W        = 5;
  localparam int IB_FETCH_W      = 8;
  localparam int IB_ISSUE_W      = 4;
  localparam int IB_FLUSH_SHADOW = 1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} ib_state_t;
endpackage

// File: rtl/inst_buf_ctrl_if.sv
// Fetch/decode side bundle of the instruction buffer controller.
interface inst_buf_ctrl_if
  import ib_pkg::*;
#(
  parameter int PTR_W   = IB_PTR_W,
  parameter int FETCH_W = IB_FETCH_W,
  parameter int ISSUE_W = IB_ISSUE_W
);
  logic               flush_i;
  logic [FETCH_W-1:0] fetch_vld_i;
  logic               fetch_rdy_o;
  logic               dec_rdy_i;
  logic               wr_en_o;
  logic [PTR_W-1:0]   wr_ptr_o;
  logic [3:0]         wr_cnt_o;
  logic [PTR_W-1:0]   rd_ptr_o;
  logic [ISSUE_W-1:0] issue_vld_o;
  logic [PTR_W:0]     count_o;
  logic               empty_o;
  logic               full_o;
  logic               ovf_o;

  modport master (
    output flush_i, fetch_vld_i, dec_rdy_i,
    input  fetch_rdy_o, wr_en_o, wr_ptr_o, wr_cnt_o, rd_ptr_o, issue_vld_o,
           count_o, empty_o, full_o, ovf_o
  );

  modport slave (
    input  flush_i, fetch_vld_i, dec_rdy_i,
    output fetch_rdy_o, wr_en_o, wr_ptr_o, wr_cnt_o, rd_ptr_o, issue_vld_o,
           count_o, empty_o, full_o, ovf_o
  );
endinterface

// File: rtl/ib_lead_ones.sv
// Length of the run of ones starting at slot 0, plus a flag for any valid slot past a hole.
module ib_lead_ones #(
  parameter int FETCH_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic [FETCH_W-1:0] vld,
  output logic [CNT_W-1:0]   cnt,
  output logic               gap
);
  logic run;

  always_comb begin
    run = 1'b1;
    cnt = '0;
    gap = 1'b0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (run && vld[i]) cnt = cnt + CNT_W'(1);
      else begin
        run = 1'b0;
        gap = gap | vld[i];
      end
    end
  end
endmodule

// File: rtl/inst_buf_ctrl.sv
// Pointer/occupancy sequencer for the 32-entry fetch->decode buffer with flush shadow.
module inst_buf_ctrl
  import ib_pkg::*;
#(
  parameter int DEPTH        = IB_DEPTH,
  parameter int PTR_W        = IB_PTR_W,
  parameter int FETCH_W      = IB_FETCH_W,
  parameter int ISSUE_W      = IB_ISSUE_W,
  parameter int FLUSH_SHADOW = IB_FLUSH_SHADOW
) (
  input  logic           clock,
  input  logic           reset,
  inst_buf_ctrl_if.slave bus
);
  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_FLUSH = FLUSH;
  localparam int         AV_W     = $clog2(ISSUE_W + 1);
  localparam int         CNT_W    = PTR_W + 1;

  logic [0:0]       state_q;
  logic [1:0]       shadow_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [3:0]       lead_cnt, wr_cnt;
  logic             gap, in_run, fetch_rdy, wr_en, proto_err;
  logic [AV_W-1:0]  avail, rd_cnt;

  ib_lead_ones #(.FETCH_W(FETCH_W), .CNT_W(4)) u_lead (
    .vld (bus.fetch_vld_i),
    .cnt (lead_cnt),
    .gap (gap)
  );

  // Ready is a pure function of registered occupancy: no input->ready path.
  assign in_run    = (state_q == ST_RUN);
  assign fetch_rdy = in_run && (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign wr_en     = fetch_rdy && !bus.flush_i && (lead_cnt != 4'd0);
  assign wr_cnt    = wr_en ? lead_cnt : 4'd0;

  assign avail  = !in_run ? '0 :
                  (count_q >= CNT_W'(ISSUE_W)) ? AV_W'(ISSUE_W) : AV_W'(count_q);
  assign rd_cnt = (bus.dec_rdy_i && !bus.flush_i) ? avail : '0;

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_therm
    assign bus.issue_vld_o[g] = (avail > AV_W'(g));
  end

  // Dropped bundles and holes in the valid mask are both protocol errors, but only in RUN.
  assign proto_err = in_run && ((|bus.fetch_vld_i && !fetch_rdy) || (fetch_rdy && gap));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      shadow_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= ovf_q | proto_err;
      if (bus.flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        if (FLUSH_SHADOW > 0) begin
          state_q  <= ST_FLUSH;
          shadow_q <= 2'(FLUSH_SHADOW);
        end else begin
          state_q  <= ST_RUN;
        end
      end else if (state_q == ST_FLUSH) begin
        shadow_q <= shadow_q - 2'd1;
        if (shadow_q <= 2'd1) state_q <= ST_RUN;
      end else begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt);
        rd_ptr_q <= rd_ptr_q + PTR_W'(rd_cnt);
        count_q  <= count_q + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
      end
    end
  end

  assign bus.fetch_rdy_o = fetch_rdy;
  assign bus.wr_en_o     = wr_en;
  assign bus.wr_cnt_o    = wr_cnt;
  assign bus.wr_ptr_o    = wr_ptr_q;
  assign bus.rd_ptr_o    = rd_ptr_q;
  assign bus.count_o     = count_q;
  assign bus.empty_o     = (count_q == '0);
  assign bus.full_o      = in_run && !fetch_rdy;
  assign bus.ovf_o       = ovf_q;
endmodule

// File: doc/inst_buf_ctrl.md
# inst_buf_ctrl

Sequencing controller for the 32-entry decoupling instruction buffer between fetch and decode. It owns the write and read pointers, the occupancy count and the fetch back-pressure. It also owns the flush/shadow state machine that discards wrong-path bundles. It issues 0–4 instructions per cycle to decode, so it can issue partial groups. The buffer storage array is driven entirely from this block's pointer, count and enable outputs.

## Interface
Parameters:
- DEPTH, 32, buffer entries (power of two)
- PTR_W, 5, log2(DEPTH)
- FETCH_W, 8, max instructions written per cycle
- ISSUE_W, 4, max instructions read per cycle
- FLUSH_SHADOW, 1, cycles of fetch input discarded after a flush (0–3)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- flush_i  in  1  redirect; empties the buffer
- fetch_vld_i  in  FETCH_W  per-slot valid of the incoming bundle
- fetch_rdy_o  out  1  buffer can accept a full bundle this cycle
- dec_rdy_i  in  1  decode consumes the offered group this cycle
- wr_en_o  out  1  storage write strobe
- wr_ptr_o  out  PTR_W  entry receiving slot 0 (slot k → wr_ptr+k mod DEPTH)
- wr_cnt_o  out  4  instructions written this cycle
- rd_ptr_o  out  PTR_W  entry holding issue slot 0
- issue_vld_o  out  ISSUE_W  thermometer of valid issue slots
- count_o  out  6  occupancy, 0..DEPTH
- empty_o / full_o  out  1  count==0 / fetch_rdy_o==0 while in RUN
- ovf_o  out  1  sticky protocol error

## Operation
- States: RUN, FLUSH. Reset → RUN; ptrs = 0, count = 0, shadow counter = 0, ovf_o = 0.
- **Write count:**
  - wr_cnt = the length of the contiguous run of ones starting at fetch_vld_i[0].
  - If bit 0 is clear, wr_cnt = 0.
  - Any set bit above that run → set ovf_o; those bits are ignored.
- **Write enable:**
  - fetch_rdy_o = (state==RUN) && (DEPTH − count ≥ FETCH_W).
  - wr_en_o = fetch_rdy_o && wr_cnt≠0.
  - If fetch_vld_i≠0 while fetch_rdy_o==0 in RUN: the bundle is dropped and ovf_o is set.
- **Read count:**
  - avail = min(count, ISSUE_W) in RUN, 0 in FLUSH.
  - issue_vld_o = thermometer(avail).
  - rd_cnt = dec_rdy_i ? avail : 0.
- **Update on each cycle in RUN:**
  - wr_ptr += wr_cnt (when wr_en), mod DEPTH.
  - rd_ptr += rd_cnt, mod DEPTH.
  - count += wr_cnt − rd_cnt.
  - Simultaneous read and write are both applied.
- **Wrap-around:** pointer arithmetic is plain PTR_W-bit modulo. No boundary special cases.
- **Flush:**
  - flush_i has priority over read and write in the same cycle; both are suppressed.
  - Next cycle: ptrs = 0, count = 0.
  - If FLUSH_SHADOW>0: state = FLUSH and the shadow counter is loaded with FLUSH_SHADOW. Otherwise the state stays RUN.
- **FLUSH state:**
  - fetch_rdy_o = 0, wr_en_o = 0, issue_vld_o = 0.
  - fetch_vld_i is ignored; it never sets ovf_o.
  - The counter decrements each cycle; at 1 → RUN.
  - flush_i in FLUSH reloads the counter.
- ovf_o is cleared only by reset.

## Timing
- wr_en_o, wr_cnt_o and rd_cnt are combinational from inputs and registered state.
- fetch_rdy_o, issue_vld_o, rd_ptr_o, wr_ptr_o, count_o, empty_o and full_o depend on registered state only. There is no input→ready path.
- Write-to-issue latency is 1 cycle; there is no same-cycle bypass into issue_vld_o.
- After flush_i in cycle T:
  - count_o = 0 at T+1.
  - fetch_rdy_o is first high at T+1+FLUSH_SHADOW.
- A full bundle is accepted whenever count ≤ DEPTH−FETCH_W (i.e. ≤24), so the buffer never overflows.

## Structure
- Package ib_pkg holds:
  - IB_DEPTH, IB_PTR_W, IB_FETCH_W, IB_ISSUE_W
  - the state enum ib_state_t {RUN, FLUSH}
- One sub-module, ib_lead_ones: leading-ones count of fetch_vld_i from bit 0, plus the non-contiguous flag.
- Storage stays outside this block.

## Test plan
- **Reset then single bundle:** reset, then fetch_vld_i=8'hFF, dec_rdy_i=0.
  - T+1: count_o=8, wr_ptr_o=8, issue_vld_o=4'hF.
- **Fill to back-pressure:** 4 bundles of 8'hFF with dec_rdy_i=0.
  - The 4th bundle (count=24) is still accepted, giving count=32.
  - Then fetch_rdy_o=0 and full_o=1; a 5th bundle sets ovf_o and count stays 32.
- **Partial issue and wrap:** after count=6 with rd_ptr=30 and dec_rdy_i=1:
  - Cycle 1 issues 4'hF, rd_ptr → 2.
  - Cycle 2 issues 4'h3, rd_ptr → 4, empty_o=1.
- **Simultaneous read/write:** count=10, fetch_vld_i=8'h1F, dec_rdy_i=1.
  - count → 11, wr_cnt_o=5.
- **Non-contiguous mask:** fetch_vld_i=8'h0B.
  - wr_cnt_o=2 and ovf_o set.
  - With 8'hFE: wr_cnt_o=0, wr_en_o=0.
- **Flush mid-stream:** flush_i with count=20 alongside a valid write and dec_rdy_i=1.
  - T+1: count=0, state FLUSH, a bundle at T+1 is ignored (no ovf).
  - T+2 (FLUSH_SHADOW=1): fetch_rdy_o=1.
  - Reset asserted mid-FLUSH returns to RUN with all outputs zero.
